keypad_scan_decoder: RTL and testbench

//  Converts the PS/2 scan-code byte stream (from the PS/2 byte receiver) into per-key held levels and press pulses.
//  It is the producing end of the keyXIsPressed inputs consumed by the flipper, pause and level blocks.

---
 rtl/keypad_scan_decoder.sv | 126 ++++++++++++
 tb/tb_keypad_scan_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_decoder.sv
// keypad_scan_decoder
//   Turns the PS/2 scan-code byte stream into per-key held levels and
//   one-cycle press pulses for keypad 2/4/5/6/8 and keypad Enter.
//   Handles make, break (F0) and extended (E0) prefixes. Typematic repeats
//   produce no extra pulse. A sequence that stalls between bytes is dropped
//   by a timeout.
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   byteValid/byteData one-cycle strobe plus received scan-code byte
//   key*IsPressed      held level per key
//   keyPressPulse[5:0] 0->1 pulse per key, order {Enter,8,6,5,4,2}
//   seqError           pulse on an illegal prefix byte or a sequence timeout
module keypad_scan_decoder #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_500_000,
  parameter bit          ARROWS_ALIAS   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byteValid,
  input  logic [7:0] byteData,
  output logic       key2IsPressed,
  output logic       key4IsPressed,
  output logic       key5IsPressed,
  output logic       key6IsPressed,
  output logic       key8IsPressed,
  output logic       keyEnterIsPressed,
  output logic [5:0] keyPressPulse,
  output logic       seqError
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EXT     = 2'd1;
  localparam logic [1:0] BRK     = 2'd2;
  localparam logic [1:0] EXT_BRK = 2'd3;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  logic [1:0]  r_state, w_state_nxt;
  logic [31:0] r_tcnt;
  logic [5:0]  r_held, w_held_nxt;
  logic [5:0]  r_pulse;
  logic        r_serr, w_serr_nxt;
  logic        w_ext, w_brk, w_timeout;
  logic [5:0]  w_mask;

  // In IDLE both flags are 0, so a plain byte there decodes as a
  // non-extended make.
  assign w_ext     = (r_state == EXT) || (r_state == EXT_BRK);
  assign w_brk     = (r_state == BRK) || (r_state == EXT_BRK);
  assign w_timeout = (r_state != IDLE) && (r_tcnt == TIMEOUT_CYCLES - 32'd1);

  // Key bit addressed by the current byte; zero for unmapped codes.
  always_comb begin
    w_mask = '0;
    case (byteData)
      8'h72: if (!w_ext || ARROWS_ALIAS) w_mask = 6'b000001;
      8'h6B: if (!w_ext || ARROWS_ALIAS) w_mask = 6'b000010;
      8'h73: if (!w_ext)                 w_mask = 6'b000100;
      8'h74: if (!w_ext || ARROWS_ALIAS) w_mask = 6'b001000;
      8'h75: if (!w_ext || ARROWS_ALIAS) w_mask = 6'b010000;
      8'h5A: if (w_ext)                  w_mask = 6'b100000;
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_held_nxt  = r_held;
    w_serr_nxt  = 1'b0;
    if (byteValid) begin
      // A byte always wins over a timeout expiring in the same cycle.
      case (r_state)
        IDLE: begin
          if (byteData == PFX_EXT)      w_state_nxt = EXT;
          else if (byteData == PFX_BRK) w_state_nxt = BRK;
          else                          w_held_nxt  = r_held | w_mask;
        end
        EXT: begin
          if (byteData == PFX_BRK)      w_state_nxt = EXT_BRK;
          else if (byteData == PFX_EXT) w_serr_nxt  = 1'b1;
          else begin
            w_held_nxt  = r_held | w_mask;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          if (byteData == PFX_EXT || byteData == PFX_BRK) w_serr_nxt = 1'b1;
          else if (w_brk) w_held_nxt = r_held & ~w_mask;
        end
      endcase
    end else if (w_timeout) begin
      w_state_nxt = IDLE;
      w_serr_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_tcnt  <= '0;
      r_held  <= '0;
      r_pulse <= '0;
      r_serr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_held  <= w_held_nxt;
      r_pulse <= w_held_nxt & ~r_held;
      r_serr  <= w_serr_nxt;
      // Saturating count of idle cycles inside a sequence.
      if (byteValid || w_timeout)
        r_tcnt <= '0;
      else if (r_state != IDLE && r_tcnt != TIMEOUT_CYCLES - 32'd1)
        r_tcnt <= r_tcnt + 32'd1;
    end
  end

  assign key2IsPressed     = r_held[0];
  assign key4IsPressed     = r_held[1];
  assign key5IsPressed     = r_held[2];
  assign key6IsPressed     = r_held[3];
  assign key8IsPressed     = r_held[4];
  assign keyEnterIsPressed = r_held[5];
  assign keyPressPulse     = r_pulse;
  assign seqError          = r_serr;
endmodule

// File: tb/tb_keypad_scan_decoder.sv
module tb_keypad_scan_decoder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bv = 1'b0;
  logic [7:0] bd = 8'h00;

  logic       k2a, k4a, k5a, k6a, k8a, kea, sea;
  logic       k2b, k4b, k5b, k6b, k8b, keb, seb;
  logic [5:0] pa, pb;
  logic [5:0] ha, hb;

  always #5 clk = ~clk;

  // dut0: arrows alias keypad keys; dut1: arrows ignored. Same stimulus.
  keypad_scan_decoder #(.TIMEOUT_CYCLES(32'd16), .ARROWS_ALIAS(1'b1)) dut0 (
    .clk(clk), .reset(reset), .byteValid(bv), .byteData(bd),
    .key2IsPressed(k2a), .key4IsPressed(k4a), .key5IsPressed(k5a),
    .key6IsPressed(k6a), .key8IsPressed(k8a), .keyEnterIsPressed(kea),
    .keyPressPulse(pa), .seqError(sea));

  keypad_scan_decoder #(.TIMEOUT_CYCLES(32'd16), .ARROWS_ALIAS(1'b0)) dut1 (
    .clk(clk), .reset(reset), .byteValid(bv), .byteData(bd),
    .key2IsPressed(k2b), .key4IsPressed(k4b), .key5IsPressed(k5b),
    .key6IsPressed(k6b), .key8IsPressed(k8b), .keyEnterIsPressed(keb),
    .keyPressPulse(pb), .seqError(seb));

  assign ha = {kea, k8a, k6a, k5a, k4a, k2a};
  assign hb = {keb, k8b, k6b, k5b, k4b, k2b};

  // Expected events: {held[5:0], pulse[5:0], seqError}
  logic [12:0] q0[$];
  logic [12:0] q1[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          snap = 1'b0;
  bit          done = 1'b0;
  logic [5:0]  prev0 = '0;
  logic [5:0]  prev1 = '0;
  logic [12:0] exp_v;

  task automatic cmp(input int d, input logic [12:0] act);
    checks++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL dut%0d unexpected_event got held=%b pulse=%b err=%b, required none",
               d, act[12:7], act[6:1], act[0]);
    end else begin
      exp_v = (d == 0) ? q0.pop_front() : q1.pop_front();
      if (act !== exp_v) begin
        errors++;
        $display("FAIL dut%0d event got held=%b pulse=%b err=%b, required held=%b pulse=%b err=%b",
                 d, act[12:7], act[6:1], act[0], exp_v[12:7], exp_v[6:1], exp_v[0]);
      end
    end
  endtask

  // Monitor: any pulse, seqError or held-level change is an output event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (snap || pa != 6'd0 || sea || ha != prev0) cmp(0, {ha, pa, sea});
      if (snap || pb != 6'd0 || seb || hb != prev1) cmp(1, {hb, pb, seb});
      prev0 <= ha;
      prev1 <= hb;
      if (done) begin
        checks += 2;
        if (q0.size() != 0) begin
          errors++;
          $display("FAIL dut0 missing_events got %0d pending, required 0", q0.size());
        end
        if (q1.size() != 0) begin
          errors++;
          $display("FAIL dut1 missing_events got %0d pending, required 0", q1.size());
        end
      end
    end
  end

  // Every stimulus task is entered just after a posedge and leaves the same way.
  task automatic send(input logic [7:0] b);
    bv = 1'b1; bd = b;
    @(posedge clk); #1;
    bv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic e0(input logic [5:0] h, input logic [5:0] p, input logic s);
    q0.push_back({h, p, s});
  endtask

  task automatic e1(input logic [5:0] h, input logic [5:0] p, input logic s);
    q1.push_back({h, p, s});
  endtask

  task automatic eb(input logic [5:0] h, input logic [5:0] p, input logic s);
    e0(h, p, s); e1(h, p, s);
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    // Reset state: everything zero.
    eb(6'b0, 6'b0, 1'b0);
    snap = 1'b1; mon_en = 1'b1;
    idle(1);
    snap = 1'b0;

    // Make / break of keypad 4.
    eb(6'b000010, 6'b000010, 1'b0); send(8'h6B);
    idle(2);
    eb(6'b000000, 6'b000000, 1'b0); send(8'hF0); send(8'h6B);
    idle(2);

    // Typematic: five makes, one pulse.
    eb(6'b000001, 6'b000001, 1'b0);
    repeat (5) send(8'h72);
    eb(6'b000000, 6'b000000, 1'b0); send(8'hF0); send(8'h72);
    idle(2);

    // Keypad Enter; non-extended 5A ignored.
    eb(6'b100000, 6'b100000, 1'b0); send(8'hE0); send(8'h5A);
    eb(6'b000000, 6'b000000, 1'b0); send(8'hE0); send(8'hF0); send(8'h5A);
    send(8'h5A);
    idle(2);

    // Arrow aliasing.
    e0(6'b001000, 6'b001000, 1'b0); send(8'hE0); send(8'h74);
    e0(6'b000000, 6'b000000, 1'b0); send(8'hE0); send(8'hF0); send(8'h74);
    eb(6'b001000, 6'b001000, 1'b0); send(8'h74);
    send(8'hE0); send(8'h74);
    e0(6'b000000, 6'b000000, 1'b0); send(8'hE0); send(8'hF0); send(8'h74);
    e1(6'b000000, 6'b000000, 1'b0); send(8'hF0); send(8'h74);
    idle(2);

    // Timeout after F0, then a plain make.
    eb(6'b000000, 6'b000000, 1'b1); send(8'hF0);
    idle(20);
    eb(6'b010000, 6'b010000, 1'b0); send(8'h75);

    // E0 E0: error but stays extended; then extended 6B.
    eb(6'b010000, 6'b000000, 1'b1); send(8'hE0); send(8'hE0);
    e0(6'b010010, 6'b000010, 1'b0); send(8'h6B);
    // F0 E0: error, back to idle.
    e0(6'b010010, 6'b000000, 1'b1); e1(6'b010000, 6'b000000, 1'b1);
    send(8'hF0); send(8'hE0);
    // Pause-key bytes: silently unmapped.
    send(8'hE1); send(8'h14); send(8'h77); send(8'hAA);
    e0(6'b000010, 6'b000000, 1'b0); e1(6'b000000, 6'b000000, 1'b0);
    send(8'hF0); send(8'h75);
    idle(2);

    // Byte arriving on the expiry cycle is processed, timeout dropped.
    e1(6'b000010, 6'b000010, 1'b0); send(8'h6B);
    send(8'hF0);
    idle(15);
    eb(6'b000000, 6'b000000, 1'b0); send(8'h6B);
    idle(2);

    // Reset mid E0 F0 with keys held.
    eb(6'b000001, 6'b000001, 1'b0); send(8'h72);
    eb(6'b001001, 6'b001000, 1'b0); send(8'h74);
    send(8'hE0); send(8'hF0);
    eb(6'b000000, 6'b000000, 1'b0);
    reset = 1'b1; idle(1); reset = 1'b0;
    eb(6'b000100, 6'b000100, 1'b0); send(8'h73);

    idle(5);
    done = 1'b1;
    idle(1);
    done = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
